irq_f2p_sched: RTL and testbench
================================

Name: irq_f2p_sched

Overview:
- Aggregates NUM_SRC fabric event sources onto the two PS interrupt inputs: irq_level feeds IRQ_F2P0 (active-high level) and irq_edge feeds IRQ_F2P1 (rising edge).
- Latches events as pending and serves them one at a time in fixed priority, lowest index first.
- Holds the interrupt until the PS acknowledges it with the matching id, then enforces a quiet gap.
- Sits in the clk100_fclk0 domain between fabric event generators and the PS7 IRQ_F2P pins.

Parameters:
- NUM_SRC, 8: number of event sources, 2..16.
- PULSE_LEN, 256: cycles irq_edge stays high per interrupt, at least 1.
- GAP_LEN, 16: idle cycles between interrupts with both outputs low, at least 1.
- ID_W, $clog2(NUM_SRC): width of the source id.

Ports:
- clk100_fclk0  in   1        FCLK0 100 MHz; the only clock.
- rst_n  in   1        Synchronous active-low reset.
- src_evt  in   NUM_SRC  Event inputs, already synchronous to clk100_fclk0; each rising edge is one event.
- src_mask  in   NUM_SRC  1 = source not eligible for service.
- irq_ack  in   1        Single-cycle acknowledge strobe from the PS (via GPIO/AXI register).
- irq_ack_id  in   ID_W     Id being acknowledged; sampled only when irq_ack=1.
- ovf_clr  in   1        Single-cycle strobe; clears overflow and ack_err.
- irq_level  out  1        Level interrupt to IRQ_F2P0.
- irq_edge  out  1        Edge interrupt to IRQ_F2P1.
- irq_id  out  ID_W     Id of the source in service; valid while irq_level=1.
- pending  out  NUM_SRC  Pending bits.
- overflow  out  NUM_SRC  Sticky: an event arrived while that source was already pending.
- ack_err  out  1        Sticky: irq_ack with a wrong id, or irq_ack outside ASSERT/WAIT_ACK.

Behaviour:
- Reset: all sequential state is cleared on the first rising clock edge with rst_n=0. This gives irq_level=0, irq_edge=0, irq_id=0, pending=0, overflow=0, ack_err=0, src_evt history=0, counters=0, state=IDLE.
  - Reset mid-service drops both IRQ outputs immediately and discards every pending event.
  - A source held high at reset release counts as one event, because history resets to 0.
- Event capture:
  - evt_rise[i] = src_evt[i] & ~hist[i], where hist is registered every cycle.
  - On evt_rise[i], pending[i] is set on the same edge.
  - If pending[i] is already 1, or is being set by another path, overflow[i] is also set.
  - Masked sources still capture pending bits and overflow.
- Clear vs set: pending[i] is cleared only by a valid ack for i. If evt_rise[i] and the valid ack for i occur in the same cycle, set wins: pending stays 1 and overflow is not set.
- FSM states: IDLE, ASSERT, WAIT_ACK, GAP.
  - IDLE: when any (pending & ~src_mask) bit is set, latch irq_id = lowest such index and load cnt = PULSE_LEN-1. Next state is ASSERT, and irq_level and irq_edge go to 1 on the same edge.
  - ASSERT: irq_level=1 and irq_edge=1; cnt decrements each cycle.
    - Valid ack: clear pending[irq_id], drop both outputs, load cnt = GAP_LEN-1, go to GAP.
    - Else, at cnt==0: drop irq_edge and go to WAIT_ACK.
  - WAIT_ACK: irq_level=1, irq_edge=0. Wait indefinitely; on a valid ack, do the same as in ASSERT.
  - GAP: both outputs 0; decrement cnt; at cnt==0 go to IDLE. Arbitration resumes the next cycle.
- Valid ack means: irq_ack=1 and irq_ack_id==irq_id, in ASSERT or WAIT_ACK.
  - Any other irq_ack sets ack_err and has no other effect.
  - ovf_clr in the same cycle as a new error: the set wins.
- Masking the in-service source after selection does not retract the interrupt. Its mask matters only at the next arbitration.
- Latency:
  - src_evt rising sampled at edge k gives pending=1 after edge k.
  - irq_level=1 after edge k+1 when in IDLE.
  - Ack sampled at edge a gives irq_level=0 after edge a.
  - Minimum spacing between consecutive interrupts: GAP_LEN+1 cycles low.
- Priority is fixed and non-preemptive. A higher-priority event arriving during service waits for the current ack plus the gap.
- Counters: cnt width is $clog2(max(PULSE_LEN,GAP_LEN)+1); it never wraps because it is reloaded before use.

Test Plan:
- Single event, PULSE_LEN=4, GAP_LEN=2:
  - Stimulus: pulse src_evt[3] at cycle 10; no ack.
  - Required: pending[3]=1 at cycle 11; irq_level and irq_edge =1 at cycle 12 with irq_id=3; irq_edge=0 at cycle 16; irq_level stays 1.
  - Then ack id 3 at cycle 20: irq_level=0 at 21; pending=0.
- Priority:
  - Stimulus: src_evt[5] and src_evt[1] rise in the same cycle.
  - Required: id 1 served first; after its ack plus a 2-cycle gap, id 5 asserts. No overflow.
- Overflow and set-wins:
  - Stimulus: second rise of src_evt[2] while pending[2]=1 → overflow[2]=1. Then a rise of src_evt[2] in the same cycle as the valid ack for id 2.
  - Required: pending[2] stays 1, and id 2 is served again after the gap.
  - Then ovf_clr → overflow=0.
- Bad ack and mask:
  - Ack id 4 while serving id 0 → ack_err=1, irq_level stays 1.
  - Ack while in IDLE → ack_err=1.
  - With src_mask[6]=1 and pending[6]=1 → no interrupt. Unmasking → irq_id=6 one cycle later.
- Reset mid-service:
  - Stimulus: rst_n=0 for 1 cycle during ASSERT with pending=8'hA5.
  - Required: all outputs 0 after that edge. With src_evt=8'h01 held high at release, id 0 asserts 2 cycles after release.

Source files
------------

// File: rtl/irq_f2p_sched.sv
// irq_f2p_sched: latches fabric events and serves them one at a time onto IRQ_F2P0 (level) and IRQ_F2P1 (edge).
module irq_f2p_sched #(
  parameter int NUM_SRC = 8,
  parameter int PULSE_LEN = 256,
  parameter int GAP_LEN = 16,
  parameter int ID_W = $clog2(NUM_SRC)
) (
  input  logic               clk100_fclk0,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_evt,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               irq_ack,
  input  logic [ID_W-1:0]    irq_ack_id,
  input  logic               ovf_clr,
  output logic               irq_level,
  output logic               irq_edge,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] overflow,
  output logic               ack_err
);
  localparam int CMAX = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [1:0] {IDLE, ASSERT, WAIT_ACK, GAP} state_t;
  state_t state;
  logic [NUM_SRC-1:0] hist, evt_rise, clr, elig;
  logic [CW-1:0] cnt;
  logic [ID_W-1:0] sel;
  logic valid_ack;
  always_comb begin
    evt_rise = src_evt & ~hist;
    elig = pending & ~src_mask;
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) sel = ID_W'(i);
    valid_ack = irq_ack && (state == ASSERT || state == WAIT_ACK) && irq_ack_id == irq_id;
    clr = valid_ack ? NUM_SRC'(1) << irq_id : '0;
  end
  // A rise coinciding with the clearing ack re-arms the source without counting as overflow.
  always_ff @(posedge clk100_fclk0) begin
    if (!rst_n) begin
      state <= IDLE;
      hist <= '0;
      pending <= '0;
      overflow <= '0;
      ack_err <= 1'b0;
      irq_level <= 1'b0;
      irq_edge <= 1'b0;
      irq_id <= '0;
      cnt <= '0;
    end else begin
      hist <= src_evt;
      pending <= (pending & ~clr) | evt_rise;
      overflow <= (ovf_clr ? '0 : overflow) | (evt_rise & pending & ~clr);
      ack_err <= (irq_ack && !valid_ack) || (ack_err && !ovf_clr);
      case (state)
        IDLE: if (|elig) begin
          irq_id <= sel;
          cnt <= CW'(PULSE_LEN - 1);
          irq_level <= 1'b1;
          irq_edge <= 1'b1;
          state <= ASSERT;
        end
        ASSERT, WAIT_ACK: if (valid_ack) begin
          irq_level <= 1'b0;
          irq_edge <= 1'b0;
          cnt <= CW'(GAP_LEN - 1);
          state <= GAP;
        end else if (state == ASSERT) begin
          if (cnt == '0) begin
            irq_edge <= 1'b0;
            state <= WAIT_ACK;
          end else cnt <= cnt - 1'b1;
        end
        GAP: if (cnt == '0) state <= IDLE;
             else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_f2p_sched.sv
// tb_irq_f2p_sched: scenario tasks with a queue of expected interrupt ids, popped as each interrupt asserts.
module tb_irq_f2p_sched;
  logic clk100_fclk0 = 1'b0;
  logic rst_n;
  logic [7:0] src_evt, src_mask;
  logic irq_ack, ovf_clr;
  logic [2:0] irq_ack_id;
  logic irq_level, irq_edge, ack_err;
  logic [2:0] irq_id;
  logic [7:0] pending, overflow;
  int vectors = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_id;

  irq_f2p_sched #(.NUM_SRC(8), .PULSE_LEN(4), .GAP_LEN(2)) dut (
    .clk100_fclk0(clk100_fclk0), .rst_n(rst_n), .src_evt(src_evt), .src_mask(src_mask),
    .irq_ack(irq_ack), .irq_ack_id(irq_ack_id), .ovf_clr(ovf_clr),
    .irq_level(irq_level), .irq_edge(irq_edge), .irq_id(irq_id),
    .pending(pending), .overflow(overflow), .ack_err(ack_err)
  );

  always #5 clk100_fclk0 = ~clk100_fclk0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk100_fclk0);
      #1;
    end
  endtask

  task automatic wait_irq(input int max_cyc);
    int n = 0;
    while (!irq_level && n < max_cyc) begin
      tick(1);
      n++;
    end
    vectors++;
    if (irq_level !== 1'b1) begin
      errors++;
      $display("FAIL irq_wait: irq_level=%0b after %0d cycles, required 1", irq_level, n);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL irq_sb: irq asserted with id %0d, required none", irq_id);
    end else begin
      exp_id = exp_q.pop_front();
      if (irq_id !== exp_id) begin
        errors++;
        $display("FAIL irq_sb_id: got %0d, required %0d", irq_id, exp_id);
      end
    end
  endtask

  task automatic do_ack(input logic [2:0] id);
    irq_ack = 1'b1;
    irq_ack_id = id;
    tick(1);
    irq_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    src_evt = '0;
    src_mask = '0;
    irq_ack = 1'b0;
    irq_ack_id = '0;
    ovf_clr = 1'b0;
    tick(2);
    vectors++;
    if ({irq_level, irq_edge, irq_id, pending, overflow, ack_err} !== '0) begin
      errors++;
      $display("FAIL reset: lvl=%0b edge=%0b id=%0d pend=%h ovf=%h err=%0b, required all 0",
               irq_level, irq_edge, irq_id, pending, overflow, ack_err);
    end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single;
    src_evt = 8'h08;
    exp_q.push_back(3'd3);
    tick(1);
    src_evt = '0;
    vectors++;
    if (pending !== 8'h08 || irq_level !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pend=%h lvl=%0b, required 08 0", pending, irq_level);
    end
    tick(1);
    vectors++;
    if (irq_edge !== 1'b1) begin
      errors++;
      $display("FAIL single_edge_rise: edge=%0b, required 1", irq_edge);
    end
    wait_irq(0);
    tick(3);
    vectors++;
    if (irq_edge !== 1'b1 || irq_level !== 1'b1) begin
      errors++;
      $display("FAIL single_edge_hold: edge=%0b lvl=%0b, required 1 1", irq_edge, irq_level);
    end
    tick(1);
    vectors++;
    if (irq_edge !== 1'b0 || irq_level !== 1'b1) begin
      errors++;
      $display("FAIL single_edge_fall: edge=%0b lvl=%0b, required 0 1", irq_edge, irq_level);
    end
    tick(4);
    vectors++;
    if (irq_level !== 1'b1) begin
      errors++;
      $display("FAIL single_wait: lvl=%0b, required 1", irq_level);
    end
    do_ack(3'd3);
    vectors++;
    if (irq_level !== 1'b0 || pending !== 8'h00 || ack_err !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: lvl=%0b pend=%h err=%0b, required 0 00 0", irq_level, pending, ack_err);
    end
    tick(3);
  endtask

  task automatic test_priority;
    src_evt = 8'h22;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd5);
    tick(1);
    src_evt = '0;
    vectors++;
    if (pending !== 8'h22) begin
      errors++;
      $display("FAIL prio_pend: pend=%h, required 22", pending);
    end
    wait_irq(3);
    do_ack(3'd1);
    tick(2);
    vectors++;
    if (irq_level !== 1'b0) begin
      errors++;
      $display("FAIL prio_gap: lvl=%0b during gap, required 0", irq_level);
    end
    tick(1);
    vectors++;
    if (irq_level !== 1'b1) begin
      errors++;
      $display("FAIL prio_second: lvl=%0b after gap, required 1", irq_level);
    end
    wait_irq(0);
    vectors++;
    if (overflow !== 8'h00) begin
      errors++;
      $display("FAIL prio_ovf: ovf=%h, required 00", overflow);
    end
    do_ack(3'd5);
    tick(3);
  endtask

  task automatic test_overflow;
    src_evt = 8'h04;
    exp_q.push_back(3'd2);
    tick(1);
    src_evt = '0;
    tick(1);
    src_evt = 8'h04;
    tick(1);
    src_evt = '0;
    vectors++;
    if (overflow !== 8'h04) begin
      errors++;
      $display("FAIL ovf_set: ovf=%h, required 04", overflow);
    end
    wait_irq(2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    vectors++;
    if (overflow !== 8'h00) begin
      errors++;
      $display("FAIL ovf_clr: ovf=%h, required 00", overflow);
    end
    src_evt = 8'h04;
    exp_q.push_back(3'd2);
    do_ack(3'd2);
    src_evt = '0;
    vectors++;
    if (pending !== 8'h04 || overflow !== 8'h00 || irq_level !== 1'b0) begin
      errors++;
      $display("FAIL set_wins: pend=%h ovf=%h lvl=%0b, required 04 00 0", pending, overflow, irq_level);
    end
    wait_irq(6);
    do_ack(3'd2);
    tick(3);
    vectors++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL ovf_done: pend=%h, required 00", pending);
    end
  endtask

  task automatic test_bad_ack_mask;
    src_evt = 8'h01;
    exp_q.push_back(3'd0);
    tick(1);
    src_evt = '0;
    wait_irq(3);
    do_ack(3'd4);
    vectors++;
    if (ack_err !== 1'b1 || irq_level !== 1'b1) begin
      errors++;
      $display("FAIL bad_id: err=%0b lvl=%0b, required 1 1", ack_err, irq_level);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    vectors++;
    if (ack_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: err=%0b, required 0", ack_err);
    end
    do_ack(3'd0);
    tick(3);
    do_ack(3'd0);
    vectors++;
    if (ack_err !== 1'b1 || irq_level !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack: err=%0b lvl=%0b, required 1 0", ack_err, irq_level);
    end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    src_mask = 8'h40;
    src_evt = 8'h40;
    tick(1);
    src_evt = '0;
    tick(4);
    vectors++;
    if (pending !== 8'h40 || irq_level !== 1'b0) begin
      errors++;
      $display("FAIL masked: pend=%h lvl=%0b, required 40 0", pending, irq_level);
    end
    exp_q.push_back(3'd6);
    src_mask = '0;
    tick(1);
    wait_irq(0);
    do_ack(3'd6);
    tick(3);
  endtask

  task automatic test_reset_mid;
    src_evt = 8'hA5;
    exp_q.push_back(3'd0);
    tick(1);
    src_evt = '0;
    wait_irq(3);
    vectors++;
    if (irq_edge !== 1'b1 || pending !== 8'hA5) begin
      errors++;
      $display("FAIL pre_reset: edge=%0b pend=%h, required 1 a5", irq_edge, pending);
    end
    rst_n = 1'b0;
    src_evt = 8'h01;
    tick(1);
    vectors++;
    if ({irq_level, irq_edge, irq_id, pending, overflow, ack_err} !== '0) begin
      errors++;
      $display("FAIL mid_reset: lvl=%0b edge=%0b id=%0d pend=%h ovf=%h err=%0b, required all 0",
               irq_level, irq_edge, irq_id, pending, overflow, ack_err);
    end
    rst_n = 1'b1;
    exp_q.push_back(3'd0);
    tick(1);
    vectors++;
    if (pending !== 8'h01 || irq_level !== 1'b0) begin
      errors++;
      $display("FAIL release_pend: pend=%h lvl=%0b, required 01 0", pending, irq_level);
    end
    tick(1);
    vectors++;
    if (irq_level !== 1'b1) begin
      errors++;
      $display("FAIL release_irq: lvl=%0b, required 1", irq_level);
    end
    wait_irq(0);
    src_evt = '0;
    do_ack(3'd0);
    tick(3);
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_overflow;
    test_bad_ack_mask;
    test_reset_mid;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected ids left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
